// File: rtl/negator_rr_scheduler.sv
// negator_rr_scheduler
//
// Shares one pipelined, in-order negator datapath between N_REQ requesters.
// Operands are granted round-robin and the owner of every accepted operand
// is pushed into a small tag FIFO. Because the negator returns results in
// issue order, the FIFO head always names the owner of the next result,
// which is routed back with zero added latency.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low (0 = in reset)
//   req_valid     per-requester operand valid
//   req_ready     per-requester accept strobe (one-hot or zero)
//   req_data      packed operands, requester i at [i*WIDTH +: WIDTH]
//   dp_in_valid   operand valid towards the negator
//   dp_in_ready   negator can take an operand
//   dp_in_data    operand towards the negator
//   dp_out_valid  negator result valid (never backpressured)
//   dp_out_data   negator result
//   rsp_valid     per-requester result strobe (one-hot or zero)
//   rsp_data      result data shared by all requesters
//   inflight      operands accepted but not yet returned
//   tag_err       sticky: a result arrived while no owner was tracked
module negator_rr_scheduler #(
  parameter int N_REQ        = 2,
  parameter int WIDTH        = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*WIDTH-1:0]          req_data,
  output logic                            dp_in_valid,
  input  logic                            dp_in_ready,
  output logic [WIDTH-1:0]                dp_in_data,
  input  logic                            dp_out_valid,
  input  logic [WIDTH-1:0]                dp_out_data,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [WIDTH-1:0]                rsp_data,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            tag_err
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int AW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW    = $clog2(MAX_INFLIGHT) + 1;

  logic [TAG_W-1:0] rrPtr_q, rrPtr_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic             tagErr_q, tagErr_d;
  logic [TAG_W-1:0] tagMem_q [MAX_INFLIGHT];

  logic [TAG_W-1:0] grant;
  logic [TAG_W:0]   searchIdx;
  logic             found;
  logic             eligible;
  logic             empty;
  logic             push;
  logic             pop;

  // Round-robin search: the first valid requester starting at rrPtr_q and
  // wrapping. rrPtr_q < N_REQ and k < N_REQ, so one subtraction suffices
  // to bring the candidate index back into range.
  always_comb begin
    grant     = rrPtr_q;
    found     = 1'b0;
    searchIdx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      searchIdx = {1'b0, rrPtr_q} + (TAG_W+1)'(k);
      if (searchIdx >= (TAG_W+1)'(N_REQ)) begin
        searchIdx = searchIdx - (TAG_W+1)'(N_REQ);
      end
      if (!found && req_valid[searchIdx[TAG_W-1:0]]) begin
        grant = searchIdx[TAG_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Issue side. Eligibility uses the registered count, so a same-cycle
  // pop never unblocks a push. Outputs are gated by reset so that they
  // drop the moment reset is asserted, even with requests still pending.
  always_comb begin
    eligible    = inflight_q < CW'(MAX_INFLIGHT);
    dp_in_valid = reset & eligible & found;
    dp_in_data  = req_data[int'(grant)*WIDTH +: WIDTH];
    push        = dp_in_valid & dp_in_ready;
    req_ready   = push ? (N_REQ'(1) << grant) : '0;
  end

  // Return side. A result with no tracked owner is dropped rather than
  // misrouted; the FIFO head is only consulted when the FIFO holds a tag.
  always_comb begin
    empty     = (inflight_q == '0);
    pop       = dp_out_valid & ~empty;
    rsp_valid = pop ? (N_REQ'(1) << tagMem_q[rdPtr_q]) : '0;
    rsp_data  = dp_out_data;
  end

  // Next-state for the round-robin pointer, FIFO pointers, occupancy count
  // and the sticky fault flag.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    inflight_d = inflight_q + CW'(push) - CW'(pop);
    tagErr_d   = tagErr_q | (dp_out_valid & empty);
    if (push) begin
      rrPtr_d = (grant == TAG_W'(N_REQ-1)) ? '0 : grant + 1'b1;
      wrPtr_d = (wrPtr_q == AW'(MAX_INFLIGHT-1)) ? '0 : wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == AW'(MAX_INFLIGHT-1)) ? '0 : rdPtr_q + 1'b1;
    end
  end

  // Control state. Clearing the pointers and count empties the tag FIFO,
  // discarding any owners that were in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rrPtr_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      inflight_q <= '0;
      tagErr_q   <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      inflight_q <= inflight_d;
      tagErr_q   <= tagErr_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says
  // they were written since the last reset.
  always_ff @(posedge clock) begin
    if (push) begin
      tagMem_q[wrPtr_q] <= grant;
    end
  end

  assign inflight = inflight_q;
  assign tag_err  = tagErr_q;

endmodule

// File: tb/tb_negator_rr_scheduler.sv
module tb_negator_rr_scheduler;

  localparam int N    = 2;
  localparam int W    = 64;
  localparam int MAXI = 4;
  localparam int CW   = 3;

  logic           clock = 1'b0;
  logic           resetN;
  logic [N-1:0]   reqValid;
  logic [N-1:0]   reqReady;
  logic [N*W-1:0] reqData;
  logic           dpInValid;
  logic           dpInReady;
  logic [W-1:0]   dpInData;
  logic           dpOutValid;
  logic [W-1:0]   dpOutData;
  logic [N-1:0]   rspValid;
  logic [W-1:0]   rspData;
  logic [CW-1:0]  inflight;
  logic           tagErr;

  negator_rr_scheduler #(.N_REQ(N), .WIDTH(W), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(resetN),
    .req_valid(reqValid), .req_ready(reqReady), .req_data(reqData),
    .dp_in_valid(dpInValid), .dp_in_ready(dpInReady), .dp_in_data(dpInData),
    .dp_out_valid(dpOutValid), .dp_out_data(dpOutData),
    .rsp_valid(rspValid), .rsp_data(rspData),
    .inflight(inflight), .tag_err(tagErr)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Reference model: a queue of outstanding operations (owner + operand),
  // the round-robin start position, and the sticky fault flag.
  typedef struct {
    int           owner;
    logic [W-1:0] operand;
  } entry_t;

  entry_t outQ[$];
  int     rrModel;
  bit     errModel;

  int checks = 0;
  int errors = 0;

  bit           expDpInValid;
  logic [N-1:0] expReqReady;
  logic [N-1:0] expRspValid;
  logic [W-1:0] expDpInData;
  logic [W-1:0] expRspData;
  int           expInflight;
  bit           expTagErr;
  int           expGrant;

  // The negator is modelled as returning the negation of the oldest
  // outstanding operand; the expected outputs for the current inputs are
  // then derived from the model state.
  task automatic applyStimulus();
    dpOutData = (outQ.size() > 0) ? -outQ[0].operand : {$urandom, $urandom};
    #1;
    expGrant = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rrModel + k) % N;
      if (expGrant < 0 && reqValid[idx]) expGrant = idx;
    end
    expDpInValid = resetN && (outQ.size() < MAXI) && (expGrant >= 0);
    expDpInData  = (expGrant >= 0) ? reqData[expGrant*W +: W] : '0;
    expReqReady  = '0;
    if (expDpInValid && dpInReady) expReqReady[expGrant] = 1'b1;
    expRspValid  = '0;
    expRspData   = '0;
    if (resetN && dpOutValid && outQ.size() > 0) begin
      expRspValid[outQ[0].owner] = 1'b1;
      expRspData = -outQ[0].operand;
    end
    expInflight = outQ.size();
    expTagErr   = errModel;
  endtask

  // Clock edge: retire the popped owner, record the issued operand, and
  // latch a fault when a result arrived with nothing outstanding.
  task automatic advance();
    bit push, pop, fault;
    push  = (expReqReady != '0);
    pop   = (expRspValid != '0);
    fault = resetN && dpOutValid && (outQ.size() == 0);
    @(posedge clock);
    if (pop) void'(outQ.pop_front());
    if (push) begin
      outQ.push_back('{expGrant, expDpInData});
      rrModel = (expGrant + 1) % N;
    end
    if (fault) errModel = 1'b1;
    #1;
  endtask

  // Reset both the DUT and the modelled negator, releasing away from the edge.
  task automatic applyReset();
    resetN     = 1'b0;
    reqValid   = '0;
    reqData    = '0;
    dpInReady  = 1'b0;
    dpOutValid = 1'b0;
    outQ.delete();
    rrModel  = 0;
    errModel = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  // Outputs must be quiet while reset is held, even with live requests.
  task automatic test_reset();
    resetN     = 1'b0;
    reqValid   = 2'b11;
    reqData    = {$urandom, $urandom, $urandom, $urandom};
    dpInReady  = 1'b1;
    dpOutValid = 1'b1;
    dpOutData  = 64'd7;
    #2;
    checks++; if (dpInValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dp_in_valid got=%b exp=0", dpInValid); end
    checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=00", reqReady); end
    checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=00", rspValid); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("[TB] FAIL reset_inflight got=%0d exp=0", inflight); end
    checks++; if (tagErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_tag_err got=%b exp=0", tagErr); end
    applyReset();
  endtask

  // One operand from requester 0 goes out the same cycle and its
  // negation comes back to requester 0.
  task automatic test_single();
    applyReset();
    reqValid = 2'b01;
    reqData  = '0;
    reqData[0 +: W] = 64'd5;
    dpInReady = 1'b1;
    applyStimulus();
    checks++; if (dpInData !== 64'd5) begin errors++; $display("[TB] FAIL single_dp_in_data got=%0d exp=5", dpInData); end
    checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL single_req_ready got=%b exp=01", reqReady); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("[TB] FAIL single_inflight0 got=%0d exp=0", inflight); end
    advance();
    reqValid   = '0;
    dpOutValid = 1'b1;
    applyStimulus();
    checks++; if (inflight !== 3'd1) begin errors++; $display("[TB] FAIL single_inflight1 got=%0d exp=1", inflight); end
    checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid got=%b exp=01", rspValid); end
    checks++; if (rspData !== -64'd5) begin errors++; $display("[TB] FAIL single_rsp_data got=%h exp=%h", rspData, -64'd5); end
    advance();
    dpOutValid = 1'b0;
    applyStimulus();
    checks++; if (inflight !== 3'd0) begin errors++; $display("[TB] FAIL single_inflight2 got=%0d exp=0", inflight); end
  endtask

  // Two always-valid requesters alternate, and results come back in the
  // same alternating order.
  task automatic test_round_robin();
    applyReset();
    reqValid  = 2'b11;
    dpInReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reqData = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
      checks++; if (reqReady !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", i, reqReady, (i % 2 == 0) ? 2'b01 : 2'b10); end
      checks++; if (dpInData !== expDpInData) begin errors++; $display("[TB] FAIL rr_data%0d got=%h exp=%h", i, dpInData, expDpInData); end
      advance();
    end
    reqValid   = '0;
    dpOutValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checks++; if (rspValid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rr_rsp%0d got=%b exp=%b", i, rspValid, (i % 2 == 0) ? 2'b01 : 2'b10); end
      checks++; if (rspData !== expRspData) begin errors++; $display("[TB] FAIL rr_rsp_data%0d got=%h exp=%h", i, rspData, expRspData); end
      advance();
    end
    dpOutValid = 1'b0;
  endtask

  // With nothing returning, exactly MAXI operands are accepted; a single
  // result then frees one slot on the following cycle.
  task automatic test_fill();
    int transfers;
    transfers = 0;
    applyReset();
    reqValid  = 2'b11;
    reqData   = {$urandom, $urandom, $urandom, $urandom};
    dpInReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (reqReady != '0) transfers++;
      checks++; if (reqReady !== expReqReady) begin errors++; $display("[TB] FAIL fill_ready%0d got=%b exp=%b", i, reqReady, expReqReady); end
      advance();
    end
    checks++; if (transfers !== 4) begin errors++; $display("[TB] FAIL fill_transfers got=%0d exp=4", transfers); end
    dpOutValid = 1'b1;
    applyStimulus();
    checks++; if (inflight !== 3'd4) begin errors++; $display("[TB] FAIL fill_inflight got=%0d exp=4", inflight); end
    checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL fill_full_ready got=%b exp=00", reqReady); end
    checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL fill_pop got=%b exp=01", rspValid); end
    advance();
    dpOutValid = 1'b0;
    applyStimulus();
    checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL fill_refill got=%b exp=01", reqReady); end
    checks++; if (inflight !== 3'd3) begin errors++; $display("[TB] FAIL fill_inflight3 got=%0d exp=3", inflight); end
    advance();
    applyStimulus();
    checks++; if (inflight !== 3'd4) begin errors++; $display("[TB] FAIL fill_inflight4 got=%0d exp=4", inflight); end
  endtask

  // A push and a pop in the same cycle leave the count unchanged and the
  // owners still drain oldest-first.
  task automatic test_push_pop();
    applyReset();
    reqValid  = 2'b11;
    dpInReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      reqData = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
      advance();
    end
    reqData    = {$urandom, $urandom, $urandom, $urandom};
    dpOutValid = 1'b1;
    applyStimulus();
    checks++; if (inflight !== 3'd2) begin errors++; $display("[TB] FAIL pp_before got=%0d exp=2", inflight); end
    checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL pp_rsp got=%b exp=01", rspValid); end
    checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL pp_ready got=%b exp=01", reqReady); end
    advance();
    reqValid = '0;
    applyStimulus();
    checks++; if (inflight !== 3'd2) begin errors++; $display("[TB] FAIL pp_after got=%0d exp=2", inflight); end
    checks++; if (rspValid !== 2'b10) begin errors++; $display("[TB] FAIL pp_drain0 got=%b exp=10", rspValid); end
    advance();
    applyStimulus();
    checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL pp_drain1 got=%b exp=01", rspValid); end
    checks++; if (rspData !== expRspData) begin errors++; $display("[TB] FAIL pp_drain_data got=%h exp=%h", rspData, expRspData); end
    advance();
    dpOutValid = 1'b0;
  endtask

  // A stalled negator holds off the transfer without moving the pointer;
  // the operand goes the cycle ready rises.
  task automatic test_stall();
    applyReset();
    reqValid  = 2'b10;
    reqData   = {$urandom, $urandom, $urandom, $urandom};
    dpInReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks++; if (dpInValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d got=%b exp=1", i, dpInValid); end
      checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL stall_ready%0d got=%b exp=00", i, reqReady); end
      checks++; if (dpInData !== reqData[W +: W]) begin errors++; $display("[TB] FAIL stall_data%0d got=%h exp=%h", i, dpInData, reqData[W +: W]); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("[TB] FAIL stall_inflight%0d got=%0d exp=0", i, inflight); end
      advance();
    end
    dpInReady = 1'b1;
    applyStimulus();
    checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL stall_release got=%b exp=10", reqReady); end
    advance();
    reqValid = 2'b11;
    applyStimulus();
    checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL stall_next got=%b exp=01", reqReady); end
    advance();
    reqValid = '0;
  endtask

  // An orphan result sets a sticky error; reset mid-traffic clears
  // everything at once and a stale result afterwards is flagged again.
  task automatic test_fault();
    applyReset();
    dpOutValid = 1'b1;
    applyStimulus();
    checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL fault_rsp got=%b exp=00", rspValid); end
    advance();
    dpOutValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks++; if (tagErr !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky%0d got=%b exp=1", i, tagErr); end
      advance();
    end
    applyReset();
    reqValid  = 2'b11;
    dpInReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      reqData = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
      advance();
    end
    dpOutValid = 1'b1;
    applyStimulus();
    resetN = 1'b0;
    #1;
    checks++; if (dpInValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dp_in_valid got=%b exp=0", dpInValid); end
    checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL midrst_req_ready got=%b exp=00", reqReady); end
    checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_rsp_valid got=%b exp=00", rspValid); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("[TB] FAIL midrst_inflight got=%0d exp=0", inflight); end
    applyReset();
    dpOutValid = 1'b1;
    applyStimulus();
    checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL stale_rsp got=%b exp=00", rspValid); end
    advance();
    dpOutValid = 1'b0;
    applyStimulus();
    checks++; if (tagErr !== 1'b1) begin errors++; $display("[TB] FAIL stale_tag_err got=%b exp=1", tagErr); end
  endtask

  // Random traffic checked cycle by cycle against the model.
  task automatic test_random();
    applyReset();
    for (int i = 0; i < 300; i++) begin
      reqValid   = N'($urandom_range(0, 3));
      reqData    = {$urandom, $urandom, $urandom, $urandom};
      dpInReady  = ($urandom % 4) != 0;
      dpOutValid = (outQ.size() > 0) && ($urandom % 2 == 1);
      applyStimulus();
      checks++; if (reqReady !== expReqReady) begin errors++; $display("[TB] FAIL rnd_ready%0d got=%b exp=%b", i, reqReady, expReqReady); end
      checks++; if (dpInValid !== expDpInValid) begin errors++; $display("[TB] FAIL rnd_valid%0d got=%b exp=%b", i, dpInValid, expDpInValid); end
      if (expDpInValid) begin
        checks++; if (dpInData !== expDpInData) begin errors++; $display("[TB] FAIL rnd_data%0d got=%h exp=%h", i, dpInData, expDpInData); end
      end
      checks++; if (rspValid !== expRspValid) begin errors++; $display("[TB] FAIL rnd_rsp%0d got=%b exp=%b", i, rspValid, expRspValid); end
      if (expRspValid != '0) begin
        checks++; if (rspData !== expRspData) begin errors++; $display("[TB] FAIL rnd_rsp_data%0d got=%h exp=%h", i, rspData, expRspData); end
      end
      checks++; if (inflight !== CW'(expInflight)) begin errors++; $display("[TB] FAIL rnd_inflight%0d got=%0d exp=%0d", i, inflight, expInflight); end
      checks++; if (tagErr !== expTagErr) begin errors++; $display("[TB] FAIL rnd_tag_err%0d got=%b exp=%b", i, tagErr, expTagErr); end
      advance();
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    resetN     = 1'b0;
    reqValid   = '0;
    reqData    = '0;
    dpInReady  = 1'b0;
    dpOutValid = 1'b0;
    dpOutData  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fill();
    test_push_pop();
    test_stall();
    test_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
